regfile_wb_sched: RTL and testbench
===================================

// Module: regfile_wb_sched
// PURPOSE
//  Write-back scheduler for the 32x32 two-read/one-write register file (x0 hardwired zero).
//  - Shares the single regfile write port between NREQ write-back requesters (e.g. ALU, LSU)
//    using round-robin arbitration and a valid/ready handshake.
//  - Keeps a pending-write scoreboard so issue logic can stall on RAW and WAW hazards.
//  - Sits between the execute/memory units and the regfile write port.
// PARAMETERS
//  NREQ  2   number of write-back requesters (>=2)
//  AW    5   register address width (32 registers)
//  DW    32  register data width
// PORTS
//  clk          in   1         clock; all state updates on the rising edge
//  rst          in   1         reset, synchronous, active-high
//  req_valid    in   NREQ      requester i holds a write-back
//  req_ready    out  NREQ      grant; a transfer occurs on a cycle with valid[i] & ready[i]
//  req_addr     in   NREQ*AW   destination register; requester i in slice [i*AW +: AW]
//  req_data     in   NREQ*DW   write data; requester i in slice [i*DW +: DW]
//  rf_we        out  1         regfile write enable (registered)
//  rf_waddr     out  AW        regfile write address (registered)
//  rf_wdata     out  DW        regfile write data (registered)
//  alloc_valid  in   1         issue stage marks alloc_addr as pending
//  alloc_addr   in   AW        destination register being allocated
//  alloc_ready  out  1         allocation accepted this cycle
//  chk_addr1    in   AW        hazard-check address, read port 1
//  chk_addr2    in   AW        hazard-check address, read port 2
//  chk_busy1    out  1         pending[chk_addr1]; combinational; always 0 for x0
//  chk_busy2    out  1         pending[chk_addr2]; combinational; always 0 for x0
// BEHAVIOUR
//  Reset:
//  - rf_we=0, rf_waddr=0, rf_wdata=0, pending=0.
//  - RR pointer set so requester 0 has the highest priority.
//  - While rst=1: req_ready=0, alloc_ready=0.
//  - Reset mid-operation drops an in-flight registered write: rf_we=0 in the following cycle.
//  Arbitration:
//  - req_ready is one-hot or zero and combinational from req_valid and the RR pointer.
//  - Priority starts at the requester after the last granted one.
//  - The pointer advances only on an accepted transfer.
//  - Requesters keep valid, addr and data stable until ready. Ready does not depend on downstream.
//  Latency:
//  - A transfer accepted in cycle N gives rf_we=1 with that addr/data in cycle N+1.
//  - Back-to-back transfers are allowed: 1 write per cycle sustained.
//  - rf_we=0 on any cycle that follows a cycle with no transfer.
//  x0:
//  - A transfer to addr 0 is accepted (ready=1, pointer advances).
//  - It produces rf_we=0 in cycle N+1 and never touches the scoreboard.
//  Scoreboard (pending[31:1]):
//  - alloc_ready = ~rst & (alloc_addr==0 | ~pending[alloc_addr]); WAW on a pending reg stalls.
//  - An accepted alloc sets its pending bit at the end of that cycle; alloc to x0 sets nothing.
//  - pending[rf_waddr] clears at the end of a cycle with rf_we=1, i.e. when the regfile
//    captures the data. chk_busy is therefore still 1 in cycle N+1 and 0 in cycle N+2.
//  - Set and clear of different addresses at the same edge are both applied.
//  - Set and clear of the same address at the same edge cannot occur: alloc is stalled while
//    the bit is pending.
//  - A write-back to a non-pending register is legal: it is written, and the scoreboard is
//    unchanged.
// STRUCTURE
//  - Package regfile_pkg: AW, DW, NREGS=32, REG_X0=5'd0.
//  - Sub-module rr_arbiter (param NREQ): request vector in, one-hot grant out, pointer update
//    on an accept strobe.
//  - The top level holds the output register stage and the pending bitmap.
// TESTING (bench instantiates this block plus the regfile)
//  1. Single write-back:
//     req_valid=01, addr=5, data=32'd50 -> req_ready=01 the same cycle.
//     Next cycle rf_we=1, rf_waddr=5, rf_wdata=50. Regfile read of x5 afterwards = 50.
//  2. Round-robin:
//     Both requesters valid continuously from reset (addr 3 and 4) -> grants 0,1,0,1.
//     Regfile ends with x3 and x4 holding the last data of each requester.
//  3. x0 drop:
//     req addr=0, data=32'hDEADBEEF -> ready=1, rf_we stays 0, regfile x0 reads 0.
//  4. Hazard timing:
//     alloc x7 -> chk_busy1 (chk_addr1=7) =1 the next cycle.
//     Second alloc of x7 -> alloc_ready=0.
//     Write-back to x7 accepted in cycle N -> busy=1 in N+1, busy=0 and alloc_ready=1 in N+2.
//  5. Full scoreboard:
//     alloc x1..x31 -> all chk_busy=1, and chk on x0 =0.
//     Write back all 31 -> every bit clears, and the regfile holds i*10 for each xi.
//  6. Reset mid-operation:
//     Assert rst in the cycle after an accept -> rf_we=0 the following cycle.
//     pending=0 and req_ready=0 while rst=1; requester 0 is granted first afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants for the 32x32 register file and its write-back
//   scheduler: address and data widths, the register count, the hardwired
//   zero register, and a helper that turns a register address into a
//   one-hot bitmap position.
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int AW    = 5;          // register address width
    localparam int DW    = 32;         // register data width
    localparam int NREGS = 1 << AW;    // number of architectural registers

    localparam logic [AW-1:0] REG_X0 = '0;  // hardwired-zero register

    // One-hot bitmap position of a register address.
    function automatic logic [NREGS-1:0] reg_bit(input logic [AW-1:0] addr);
        return NREGS'(1) << addr;
    endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a one-hot grant.
//   Ports:
//     clk       clock
//     rst       synchronous active-high reset (requester 0 gets top priority)
//     req_i     request vector, one bit per requester
//     accept_i  strobe: the current grant was taken, move priority past it
//     gnt_o     one-hot (or zero) grant, combinational from req_i and state
//
//   The round-robin pointer is held as a thermometer mask of the requesters
//   that currently rank above the wrap-around point. The lowest masked
//   request wins; if nothing is masked the lowest raw request wins. After
//   a grant to requester g the mask keeps only bits strictly above g, so
//   priority restarts at g+1 and wraps to 0 once the mask empties.
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [NREQ-1:0] mask_q;
    logic [NREQ-1:0] mask_d;
    logic [NREQ-1:0] masked_req;
    logic [NREQ-1:0] pick_src;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        masked_req = req_i & mask_q;
        pick_src   = (|masked_req) ? masked_req : req_i;
        // Isolate the lowest set bit: x & -x.
        gnt_o      = pick_src & (~pick_src + ONE);
        mask_d     = mask_q;
        if (accept_i) begin
            // Bits strictly above the granted one: ~(g | (g - 1)).
            mask_d = ~(gnt_o | (gnt_o - ONE));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// ----------------------------------------------------------------------------
// regfile_wb_sched
//   Write-back scheduler for the 32x32 two-read/one-write register file.
//   Shares the single regfile write port among NREQ requesters (round-robin,
//   valid/ready), registers the winning write for one cycle, and keeps a
//   pending-write scoreboard so the issue stage can stall on RAW/WAW.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid / req_ready    per-requester handshake (ready one-hot or 0)
//     req_addr / req_data      packed per-requester address and data
//     rf_we/rf_waddr/rf_wdata  registered regfile write port
//     alloc_valid/alloc_addr   issue stage marks a destination as pending
//     alloc_ready              allocation accepted (stalls on pending reg)
//     chk_addr1/2, chk_busy1/2 combinational pending lookups (x0 never busy)
// ----------------------------------------------------------------------------
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    input  logic                 alloc_valid,
    input  logic [AW-1:0]        alloc_addr,
    output logic                 alloc_ready,
    input  logic [AW-1:0]        chk_addr1,
    input  logic [AW-1:0]        chk_addr2,
    output logic                 chk_busy1,
    output logic                 chk_busy2
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0] gnt;
    logic            accept;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // Ready never depends on downstream: the output register accepts one
    // write every cycle, so the grant is the ready.
    assign req_ready = rst ? '0 : gnt;
    assign accept    = |(req_valid & req_ready);

    // ------------------------------------------------------------------
    // Winner select
    // ------------------------------------------------------------------
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    logic          we_q,    we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    always_comb begin
        // A transfer to x0 is consumed here: it completes the handshake but
        // never reaches the regfile.
        we_d    = accept & (sel_addr != REG_X0);
        waddr_d = we_d ? sel_addr : waddr_q;
        wdata_d = we_d ? sel_data : wdata_q;
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard
    // ------------------------------------------------------------------
    logic [NREGS-1:0] pending_q, pending_d;
    logic [NREGS-1:0] set_vec, clr_vec;
    logic             alloc_fire;

    assign alloc_ready = ~rst & ((alloc_addr == REG_X0) | ~pending_q[alloc_addr]);
    assign alloc_fire  = alloc_valid & alloc_ready & (alloc_addr != REG_X0);

    always_comb begin
        set_vec = alloc_fire ? reg_bit(alloc_addr) : '0;
        // Clear when the regfile captures the data, i.e. on the cycle the
        // registered write is presented, not when the transfer is accepted.
        clr_vec = we_q ? reg_bit(waddr_q) : '0;
        // Set and clear never target the same register: alloc stalls while
        // the bit is pending, so applying both independently is safe.
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    // The bitmap is a plain flop vector, not a memory, so it takes the
    // synchronous reset like the rest of the state. Bit 0 is never set.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

    assign chk_busy1 = (chk_addr1 != REG_X0) & pending_q[chk_addr1];
    assign chk_busy2 = (chk_addr2 != REG_X0) & pending_q[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_sched
//   Directed and randomized bench for regfile_wb_sched. A small regfile
//   array is kept alongside the DUT and written from its rf_* port. The
//   reference model tracks priority as "last granted requester", the
//   scoreboard as a bit per register, and the pending write as a
//   one-deep slot.
// ----------------------------------------------------------------------------
module tb_regfile_wb_sched;
    import regfile_pkg::*;

    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [DW-1:0]        rf_wdata;
    logic                 alloc_valid;
    logic [AW-1:0]        alloc_addr;
    logic                 alloc_ready;
    logic [AW-1:0]        chk_addr1;
    logic [AW-1:0]        chk_addr2;
    logic                 chk_busy1;
    logic                 chk_busy2;

    regfile_wb_sched #(
        .NREQ (NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .chk_addr1   (chk_addr1),
        .chk_addr2   (chk_addr2),
        .chk_busy1   (chk_busy1),
        .chk_busy2   (chk_busy2)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Requester drive state (held until granted).
    bit            rv [NREQ];
    logic [AW-1:0] ra [NREQ];
    logic [DW-1:0] rd [NREQ];

    // Bench-side regfile fed from the DUT write port.
    logic [DW-1:0] rf_mem [NREGS];

    // Reference model.
    bit            m_pend [NREGS];
    logic [DW-1:0] m_regs [NREGS];
    int            m_last;
    bit            m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            last_g;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next requester after the last one granted that holds a request.
    function automatic int model_grant();
        int idx;
        if (rst) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_last + 1 + k) % NREQ;
            if (rv[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit model_busy(input logic [AW-1:0] a);
        return (a != 0) && m_pend[a];
    endfunction

    // One clock: drive, check combinational outputs, advance, check registers.
    task automatic step();
        int              g;
        logic [NREQ-1:0] exp_rdy;
        bit              exp_ar;
        logic            cur_we;
        logic [AW-1:0]   cur_wa;
        logic [DW-1:0]   cur_wd;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = rv[i];
            req_addr[i*AW +: AW]   = ra[i];
            req_data[i*DW +: DW]   = rd[i];
        end
        #1;
        g       = model_grant();
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        exp_ar  = !rst && (alloc_addr == 0 || !m_pend[alloc_addr]);
        check("req_ready",   DW'(req_ready),   DW'(exp_rdy));
        check("alloc_ready", DW'(alloc_ready), DW'(exp_ar));
        check("chk_busy1",   DW'(chk_busy1),   DW'(model_busy(chk_addr1)));
        check("chk_busy2",   DW'(chk_busy2),   DW'(model_busy(chk_addr2)));
        cur_we = rf_we;
        cur_wa = rf_waddr;
        cur_wd = rf_wdata;
        @(posedge clk);
        if (cur_we && cur_wa != 0) rf_mem[cur_wa] = cur_wd;
        // Model: the presented write lands in the regfile and retires.
        if (m_we) begin
            m_pend[m_wa] = 1'b0;
            m_regs[m_wa] = m_wd;
        end
        if (rst) begin
            for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
            m_last = NREQ - 1;
            m_we   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
        end else begin
            if (alloc_valid && exp_ar && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
            m_we = 1'b0;
            if (g >= 0) begin
                m_last = g;
                if (ra[g] != 0) begin
                    m_we = 1'b1;
                    m_wa = ra[g];
                    m_wd = rd[g];
                end
            end
        end
        #1;
        check("rf_we", DW'(rf_we), DW'(m_we));
        if (m_we) begin
            check("rf_waddr", DW'(rf_waddr), DW'(m_wa));
            check("rf_wdata", rf_wdata, m_wd);
        end
        last_g = g;
    endtask

    initial begin
        int remaining;
        int q0 [$];
        int q1 [$];
        int r;

        rst         = 1'b1;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        chk_addr1   = '0;
        chk_addr2   = '0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        last_g      = -1;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rd[i] = '0;
        end
        for (int i = 0; i < NREGS; i++) begin
            rf_mem[i] = '0; m_regs[i] = '0; m_pend[i] = 1'b0;
        end
        m_last = NREQ - 1;
        m_we = 1'b0; m_wa = '0; m_wd = '0;

        // Reset: let it take effect, then check with requests present.
        @(posedge clk);
        @(posedge clk);
        #1;
        rv[0] = 1'b1; rv[1] = 1'b1; ra[0] = 5'd3; ra[1] = 5'd4; rd[0] = 32'd300; rd[1] = 32'd400;
        step();
        check("reset_waddr", DW'(rf_waddr), '0);
        check("reset_wdata", rf_wdata, '0);

        // Round robin from reset: both requesters continuously valid.
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_order", DW'(last_g), DW'(k % 2));
            if (last_g >= 0) rd[last_g] = rd[last_g] + 32'd1;
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        step();
        check("rr_x3", rf_mem[3], 32'd301);
        check("rr_x4", rf_mem[4], 32'd401);

        // Single write-back.
        rv[0] = 1'b1; ra[0] = 5'd5; rd[0] = 32'd50;
        step();
        check("single_we",    DW'(rf_we),    32'd1);
        check("single_waddr", DW'(rf_waddr), 32'd5);
        check("single_wdata", rf_wdata,      32'd50);
        rv[0] = 1'b0;
        step();
        check("single_x5", rf_mem[5], 32'd50);

        // Write-back to x0 is accepted and dropped.
        rv[0] = 1'b1; ra[0] = 5'd0; rd[0] = 32'hDEADBEEF;
        step();
        check("x0_granted", DW'(last_g), 32'd0);
        check("x0_we",      DW'(rf_we),  32'd0);
        rv[0] = 1'b0;
        step();

        // Hazard timing on x7.
        alloc_valid = 1'b1; alloc_addr = 5'd7; chk_addr1 = 5'd7;
        step();
        check("busy_after_alloc", DW'(chk_busy1),   32'd1);
        check("waw_stall",        DW'(alloc_ready), 32'd0);
        step();
        alloc_valid = 1'b0;
        rv[1] = 1'b1; ra[1] = 5'd7; rd[1] = 32'd77;
        step();
        check("busy_n1", DW'(chk_busy1), 32'd1);
        rv[1] = 1'b0;
        step();
        check("busy_n2",        DW'(chk_busy1),   32'd0);
        check("alloc_ready_n2", DW'(alloc_ready), 32'd1);

        // Full scoreboard.
        alloc_valid = 1'b1;
        for (int i = 1; i < NREGS; i++) begin
            alloc_addr = AW'(i);
            step();
        end
        alloc_valid = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            chk_addr1 = AW'(i);
            chk_addr2 = AW'(NREGS - 1 - i);
            #1;
            check("full_busy1", DW'(chk_busy1), DW'(i != 0));
            check("full_busy2", DW'(chk_busy2), DW'(i != NREGS - 1));
        end
        for (int i = 1; i < NREGS; i++) begin
            if (i % 2) q0.push_back(i);
            else       q1.push_back(i);
        end
        for (int c = 0; c < 200 && (q0.size() + q1.size() + int'(rv[0]) + int'(rv[1])) > 0; c++) begin
            if (!rv[0] && q0.size() > 0) begin
                r = q0.pop_front(); rv[0] = 1'b1; ra[0] = AW'(r); rd[0] = DW'(r * 10);
            end
            if (!rv[1] && q1.size() > 0) begin
                r = q1.pop_front(); rv[1] = 1'b1; ra[1] = AW'(r); rd[1] = DW'(r * 10);
            end
            step();
            if (last_g >= 0) rv[last_g] = 1'b0;
        end
        remaining = q0.size() + q1.size() + int'(rv[0]) + int'(rv[1]);
        check("wb_drain", DW'(remaining), 32'd0);
        rv[0] = 1'b0; rv[1] = 1'b0;
        step();
        step();
        for (int i = 1; i < NREGS; i++) begin
            chk_addr1 = AW'(i);
            #1;
            check("drain_busy", DW'(chk_busy1), 32'd0);
            check("drain_reg",  rf_mem[i],      DW'(i * 10));
        end

        // Reset mid-operation.
        alloc_valid = 1'b1; alloc_addr = 5'd12; chk_addr2 = 5'd12;
        step();
        alloc_valid = 1'b0;
        rv[0] = 1'b1; ra[0] = 5'd9; rd[0] = 32'd99;
        step();
        rv[0] = 1'b1; ra[0] = 5'd10; rd[0] = 32'd100;
        rv[1] = 1'b1; ra[1] = 5'd11; rd[1] = 32'd110;
        rst = 1'b1;
        step();
        check("rst_we_dropped", DW'(rf_we),     32'd0);
        check("rst_ready",      DW'(req_ready), 32'd0);
        check("rst_pending",    DW'(chk_busy2), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_first", DW'(last_g), 32'd0);
        if (last_g >= 0) rv[last_g] = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] || i == last_g) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    ra[i] = AW'($urandom_range(0, 7));
                    rd[i] = $urandom;
                end
            end
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_addr  = AW'($urandom_range(0, 7));
            chk_addr1   = AW'($urandom_range(0, 7));
            chk_addr2   = AW'($urandom_range(0, 7));
            rst         = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; alloc_valid = 1'b0;
        rv[0] = 1'b0; rv[1] = 1'b0;
        step();
        step();
        for (int i = 1; i < NREGS; i++) begin
            check("final_reg", rf_mem[i], m_regs[i]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
